// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encodings
// and width helpers used by the top level and the round-robin picker.
package fifo_write_arbiter_pkg;

  // Arbiter states: free for arbitration, or locked to one burst owner.
  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_OWN  = 1'b1;

  // Index width for a requester vector; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Burst counter width: must be able to hold MAX_BURST itself.
  function automatic int unsigned cnt_width(input int unsigned max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_priority_picker.sv
// Combinational round-robin picker.
// Ports:
//   req_i        request vector
//   rr_ptr_i     index of the last winner; search starts at rr_ptr_i+1
//   winner_oh_o  one-hot winner (0 when nothing requests)
//   winner_idx_o winner index (0 when nothing requests)
//   any_o        at least one request present
module rr_priority_picker
  import fifo_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] winner_oh_o,
  output logic [IDX_W-1:0]   winner_idx_o,
  output logic               any_o
);

  int unsigned cand;

  // Walk from the farthest position back to the nearest so the nearest hit wins.
  always_comb begin
    winner_oh_o  = '0;
    winner_idx_o = '0;
    any_o        = 1'b0;
    cand         = 0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      cand = (32'(rr_ptr_i) + k) % NUM_REQ;
      if (req_i[IDX_W'(cand)]) begin
        winner_oh_o               = '0;
        winner_oh_o[IDX_W'(cand)] = 1'b1;
        winner_idx_o              = IDX_W'(cand);
        any_o                     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one CDC FIFO write port between NUM_REQ requesters with round-robin
// arbitration, burst locking up to MAX_BURST beats and a one-word registered
// output stage that honours fifo_wr_full.
// Ports:
//   clk, reset_n      FIFO write clock, async active-low reset
//   req/req_last      per-requester beat valid / last-beat-of-burst
//   req_addr/req_data packed per-requester beat payload (slice i = requester i)
//   ack               one-hot beat acceptance (combinational)
//   grant             one-hot burst owner while locked
//   busy              output stage holds a word or a burst is locked
//   fifo_wr_data/en   FIFO write side, word = {addr, data}
//   fifo_wr_full      FIFO full flag
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_last,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               ack,
  output logic [NUM_REQ-1:0]               grant,
  output logic                             busy,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_wr_data,
  output logic                             fifo_wr_en,
  input  logic                             fifo_wr_full
);

  localparam int unsigned IDX_W  = idx_width(NUM_REQ);
  localparam int unsigned CNT_W  = cnt_width(MAX_BURST);
  localparam int unsigned WORD_W = ADDR_WIDTH + DATA_WIDTH;

  logic [0:0]         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [WORD_W-1:0]  out_word_q, out_word_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               out_ready;
  logic [NUM_REQ-1:0] ack_raw;
  logic [IDX_W-1:0]   sel_idx;
  logic               load;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i        (req),
    .rr_ptr_i     (rr_ptr_q),
    .winner_oh_o  (pick_oh),
    .winner_idx_o (pick_idx),
    .any_o        (pick_any)
  );

  // The stage can take a word when empty or when its word drains this cycle.
  assign out_ready = ~out_valid_q | ~fifo_wr_full;

  // State register and output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
    end
  end

  // Next-state, acknowledge and output-stage load logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    ack_raw     = '0;
    sel_idx     = pick_idx;
    grant       = '0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_any && out_ready) begin
          ack_raw = pick_oh;
          if (req_last[pick_idx]) begin
            rr_ptr_d = pick_idx;
          end else begin
            state_d    = ARB_OWN;
            owner_d    = pick_idx;
            beat_cnt_d = CNT_W'(1);
          end
        end
      end
      ARB_OWN: begin
        sel_idx        = owner_q;
        grant[owner_q] = 1'b1;
        if (!req[owner_q]) begin
          // Owner walked away: give up the lock without accepting anything.
          state_d    = ARB_IDLE;
          rr_ptr_d   = owner_q;
          beat_cnt_d = '0;
        end else if (out_ready) begin
          ack_raw[owner_q] = 1'b1;
          beat_cnt_d       = beat_cnt_q + CNT_W'(1);
          if (req_last[owner_q] || (beat_cnt_q == CNT_W'(MAX_BURST - 1))) begin
            state_d    = ARB_IDLE;
            rr_ptr_d   = owner_q;
            beat_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    // Reset gates the acknowledge so no beat is lost while the stage is held clear.
    ack  = ack_raw & {NUM_REQ{reset_n}};
    load = |ack;

    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_word_d  = {req_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH],
                     req_data[sel_idx*DATA_WIDTH +: DATA_WIDTH]};
      out_valid_d = 1'b1;
    end else if (out_valid_q && !fifo_wr_full) begin
      out_valid_d = 1'b0;
    end
  end

  assign fifo_wr_en   = out_valid_q & ~fifo_wr_full;
  assign fifo_wr_data = out_word_q;
  assign busy         = out_valid_q | (state_q == ARB_OWN);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized bench for fifo_write_arbiter against a queue-based reference model.
module tb_fifo_write_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 17;
  localparam int unsigned DW = 8;
  localparam int unsigned MB = 16;
  localparam int unsigned WW = AW + DW;
  localparam int NCYC = 3000;
  localparam int RST_CYC = 1500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [N-1:0]  req, req_last, ack, grant;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic          busy;
  logic [WW-1:0] fifo_wr_data;
  logic          fifo_wr_en, fifo_wr_full;

  fifo_write_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_last(req_last),
    .req_addr(req_addr), .req_data(req_data), .ack(ack), .grant(grant),
    .busy(busy), .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_full(fifo_wr_full)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester behaviour: each holds a beat until acked, bursts of random length.
  bit            r_valid[N];
  bit            r_last[N];
  logic [AW-1:0] r_addr[N];
  logic [DW-1:0] r_data[N];
  int            r_rem[N];

  // Reference model: owner (-1 = free), last winner, beats in burst, pending words.
  int            m_own, m_ptr, m_cnt, win;
  logic [WW-1:0] exp_q[$];
  logic [N-1:0]  e_ack;
  int            full_pct;

  task automatic new_beat(input int i);
    r_addr[i] = AW'($urandom);
    r_data[i] = DW'($urandom);
    r_last[i] = (r_rem[i] == 1);
  endtask

  task automatic start_burst(input int i, input int len);
    r_valid[i] = 1'b1;
    r_rem[i]   = len;
    new_beat(i);
  endtask

  task automatic drive();
    for (int i = 0; i < int'(N); i++) begin
      req[i]      = r_valid[i];
      req_last[i] = r_last[i];
      req_addr[i*AW +: AW] = r_addr[i];
      req_data[i*DW +: DW] = r_data[i];
    end
  endtask

  function automatic int pick();
    for (int k = 1; k <= int'(N); k++) begin
      int c;
      c = (m_ptr + k) % int'(N);
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic expect_and_check();
    bit ready;
    logic [N-1:0] g;
    ready = (exp_q.size() == 0) || !fifo_wr_full;
    e_ack = '0;
    win   = -1;
    if (m_own < 0) begin
      win = pick();
      if (win >= 0 && ready) e_ack = N'(1) << win;
    end else if (req[m_own] && ready) begin
      e_ack = N'(1) << m_own;
    end
    g = '0;
    if (m_own >= 0) g = N'(1) << m_own;
    check_eq("ack", 64'(ack), 64'(e_ack));
    check_eq("grant", 64'(grant), 64'(g));
    check_eq("busy", 64'(busy), 64'((exp_q.size() > 0) || (m_own >= 0)));
    check_eq("wr_en", 64'(fifo_wr_en), 64'((exp_q.size() > 0) && !fifo_wr_full));
    if (exp_q.size() > 0) check_eq("wr_data", 64'(fifo_wr_data), 64'(exp_q[0]));
  endtask

  task automatic advance_model();
    int idx;
    if (exp_q.size() > 0 && !fifo_wr_full) void'(exp_q.pop_front());
    if (e_ack != '0) begin
      idx = (m_own >= 0) ? m_own : win;
      exp_q.push_back({r_addr[idx], r_data[idx]});
    end
    if (m_own < 0) begin
      if (e_ack != '0) begin
        if (req_last[win]) m_ptr = win;
        else begin
          m_own = win;
          m_cnt = 1;
        end
      end
    end else if (!req[m_own]) begin
      m_ptr = m_own;
      m_own = -1;
    end else if (e_ack != '0) begin
      m_cnt++;
      if (req_last[m_own] || m_cnt == int'(MB)) begin
        m_ptr = m_own;
        m_own = -1;
      end
    end
  endtask

  task automatic update_requesters(input logic [N-1:0] acked);
    for (int i = 0; i < int'(N); i++) begin
      if (acked[i]) begin
        r_rem[i]--;
        if (r_rem[i] == 0) r_valid[i] = 1'b0;
        else new_beat(i);
      end else if (r_valid[i]) begin
        if ($urandom_range(0, 31) == 0) begin
          r_valid[i] = 1'b0;
          r_rem[i]   = 0;
        end
      end else if ($urandom_range(0, 1) == 0) begin
        start_burst(i, int'($urandom_range(1, 20)));
      end
    end
  endtask

  task automatic model_reset();
    m_own = -1;
    m_ptr = int'(N) - 1;
    m_cnt = 0;
    exp_q.delete();
  endtask

  bit force_empty;

  initial begin
    reset_n      = 1'b0;
    fifo_wr_full = 1'b0;
    req          = '1;
    req_last     = '1;
    req_addr     = '0;
    req_data     = '0;
    model_reset();
    for (int i = 0; i < int'(N); i++) start_burst(i, 1);
    #12;
    check_eq("rst_ack", 64'(ack), 64'(0));
    check_eq("rst_grant", 64'(grant), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_wr_en", 64'(fifo_wr_en), 64'(0));
    check_eq("rst_wr_data", 64'(fifo_wr_data), 64'(0));
    @(negedge clk);
    reset_n     = 1'b1;
    force_empty = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (!reset_n) reset_n = 1'b1;
      case ((cyc / 250) % 4)
        0: full_pct = 0;
        1: full_pct = 20;
        2: full_pct = 50;
        default: full_pct = 5;
      endcase
      fifo_wr_full = force_empty ? 1'b0 : ($urandom_range(0, 99) < full_pct);
      drive();
      #1;
      expect_and_check();
      if (force_empty) begin
        check_eq("first_winner", 64'(ack), 64'(1));
        force_empty = 1'b0;
      end
      @(posedge clk);
      advance_model();
      update_requesters(e_ack);
      if (cyc == RST_CYC) begin
        // Pull reset between edges while traffic is in flight.
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_ack", 64'(ack), 64'(0));
        check_eq("mid_rst_grant", 64'(grant), 64'(0));
        check_eq("mid_rst_busy", 64'(busy), 64'(0));
        check_eq("mid_rst_wr_en", 64'(fifo_wr_en), 64'(0));
        model_reset();
        for (int i = 0; i < int'(N); i++)
          if (!r_valid[i]) start_burst(i, 1);
        force_empty = 1'b1;
        @(negedge clk);
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
